// File: rtl/wb_stream_fetch.sv
// wb_stream_fetch: Wishbone read DMA that replays a memory buffer in
// incrementing bursts into a small first-word-fall-through FIFO and presents
// the words as a valid/ready stream. A burst is only launched when the FIFO
// has room for every beat of it, so the FIFO can never overflow.
module wb_stream_fetch #(
    parameter int WB_DW         = 32,
    parameter int WB_AW         = 32,
    parameter int FIFO_AW       = 4,
    parameter int MAX_BURST_LEN = 2**FIFO_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW/8-1:0] wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic [WB_DW-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    input  logic               wbm_rty_i,
    output logic [WB_DW-1:0]   stream_m_data_o,
    output logic               stream_m_valid_o,
    input  logic               stream_m_ready_i,
    input  logic               enable,
    input  logic [WB_AW-1:0]   start_adr,
    input  logic [WB_AW-1:0]   buf_size,
    input  logic [WB_AW-1:0]   burst_size,
    output logic               busy_o,
    output logic               irq_o,
    output logic               err_o
);

    localparam int DEPTH = 2**FIFO_AW;
    localparam int LEN_W = FIFO_AW + 1;
    localparam int SEL_W = WB_DW / 8;

    localparam logic [WB_AW-1:0] BYTES_PER_WORD = WB_AW'(SEL_W);
    localparam logic [WB_AW-1:0] MAX_LEN_A      = WB_AW'(MAX_BURST_LEN);
    localparam logic [WB_AW-1:0] ONE_A          = WB_AW'(1);
    localparam logic [WB_AW-1:0] ZERO_A         = {WB_AW{1'b0}};
    localparam logic [LEN_W-1:0] DEPTH_L        = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] ONE_L          = LEN_W'(1);
    localparam logic [LEN_W-1:0] TWO_L          = LEN_W'(2);
    localparam logic [LEN_W-1:0] ZERO_L         = {LEN_W{1'b0}};
    localparam logic [2:0]       CTI_INCR       = 3'b010;
    localparam logic [2:0]       CTI_END        = 3'b111;
    localparam logic [2:0]       CTI_NONE       = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t             state_r;
    logic [WB_AW-1:0]   idx_r;
    logic [WB_AW-1:0]   adr_r;
    logic [WB_AW-1:0]   buf_size_r;
    logic [LEN_W-1:0]   beats_left_r;
    logic               cyc_r;
    logic [SEL_W-1:0]   sel_r;
    logic [2:0]         cti_r;
    logic               irq_r;
    logic               err_r;
    logic               busy_r;

    logic [WB_DW-1:0]   mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [LEN_W-1:0]   count_r;

    logic [WB_AW-1:0]   eff_len_s;
    logic [WB_AW-1:0]   remain_s;
    logic [WB_AW-1:0]   beats_s;
    logic [WB_AW-1:0]   free_s;
    logic               ack_beat_s;
    logic               err_beat_s;
    logic               last_beat_s;
    logic               buf_end_s;
    logic               fifo_wr_s;
    logic               fifo_rd_s;

    // Size of the next burst: clamped burst length, cut short at the buffer end.
    always_comb begin
        eff_len_s = ONE_A;
        remain_s  = ZERO_A;
        beats_s   = ZERO_A;
        if (burst_size == ZERO_A) begin
            eff_len_s = ONE_A;
        end else if (burst_size > MAX_LEN_A) begin
            eff_len_s = MAX_LEN_A;
        end else begin
            eff_len_s = burst_size;
        end
        if (buf_size > idx_r) begin
            remain_s = buf_size - idx_r;
        end else begin
            remain_s = ZERO_A;
        end
        if (remain_s < eff_len_s) begin
            beats_s = remain_s;
        end else begin
            beats_s = eff_len_s;
        end
        free_s = WB_AW'(DEPTH_L - count_r);
    end

    // A retry holds the beat even when ack is raised alongside it; err beats both.
    assign err_beat_s  = (state_r == ST_BURST) && cyc_r && wbm_err_i;
    assign ack_beat_s  = (state_r == ST_BURST) && cyc_r && wbm_ack_i && !wbm_err_i && !wbm_rty_i;
    assign last_beat_s = (beats_left_r == ONE_L);
    assign buf_end_s   = ((idx_r + ONE_A) == buf_size_r);
    assign fifo_wr_s   = ack_beat_s;
    assign fifo_rd_s   = (count_r != ZERO_L) && stream_m_ready_i;

    // Fetch FSM: owns every Wishbone output and the status flags as registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= ZERO_A;
            adr_r        <= ZERO_A;
            buf_size_r   <= ZERO_A;
            beats_left_r <= ZERO_L;
            cyc_r        <= 1'b0;
            sel_r        <= {SEL_W{1'b0}};
            cti_r        <= CTI_NONE;
            irq_r        <= 1'b0;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            irq_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    idx_r <= ZERO_A;
                    err_r <= enable ? err_r : 1'b0;
                    if (enable && (buf_size != ZERO_A) && !err_r) begin
                        state_r <= ST_WAIT;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (!enable || (beats_s == ZERO_A)) begin
                        // Disabled, or the buffer shrank below the current index.
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        idx_r   <= ZERO_A;
                    end else if (free_s >= beats_s) begin
                        state_r      <= ST_BURST;
                        cyc_r        <= 1'b1;
                        sel_r        <= {SEL_W{1'b1}};
                        adr_r        <= start_adr + idx_r * BYTES_PER_WORD;
                        buf_size_r   <= buf_size;
                        beats_left_r <= LEN_W'(beats_s);
                        cti_r        <= (beats_s == ONE_A) ? CTI_END : CTI_INCR;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_BURST: begin
                    if (err_beat_s) begin
                        cyc_r   <= 1'b0;
                        sel_r   <= {SEL_W{1'b0}};
                        cti_r   <= CTI_NONE;
                        err_r   <= 1'b1;
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        idx_r   <= ZERO_A;
                    end else if (ack_beat_s) begin
                        adr_r        <= adr_r + BYTES_PER_WORD;
                        beats_left_r <= beats_left_r - ONE_L;
                        cti_r        <= (beats_left_r == TWO_L) ? CTI_END : CTI_INCR;
                        if (buf_end_s) begin
                            idx_r <= ZERO_A;
                            irq_r <= 1'b1;
                        end else begin
                            idx_r <= idx_r + ONE_A;
                        end
                        if (last_beat_s) begin
                            cyc_r <= 1'b0;
                            sel_r <= {SEL_W{1'b0}};
                            cti_r <= CTI_NONE;
                            if (enable) begin
                                state_r <= ST_WAIT;
                                busy_r  <= 1'b1;
                            end else begin
                                state_r <= ST_IDLE;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            state_r <= ST_BURST;
                        end
                    end else begin
                        state_r <= ST_BURST;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cyc_r   <= 1'b0;
                    sel_r   <= {SEL_W{1'b0}};
                    cti_r   <= CTI_NONE;
                    busy_r  <= 1'b0;
                    idx_r   <= ZERO_A;
                end
            endcase
        end
    end

    // FIFO storage: no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (fifo_wr_s) begin
            mem_r[wr_ptr_r] <= wbm_dat_i;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            count_r  <= ZERO_L;
        end else begin
            if (fifo_wr_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (fifo_rd_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({fifo_wr_s, fifo_rd_s})
                2'b10:   count_r <= count_r + ONE_L;
                2'b01:   count_r <= count_r - ONE_L;
                default: count_r <= count_r;
            endcase
        end
    end

    assign wbm_adr_o        = adr_r;
    assign wbm_sel_o        = sel_r;
    assign wbm_we_o         = 1'b0;
    assign wbm_cyc_o        = cyc_r;
    assign wbm_stb_o        = cyc_r;
    assign wbm_cti_o        = cti_r;
    assign wbm_bte_o        = 2'b00;
    assign stream_m_data_o  = mem_r[rd_ptr_r];
    assign stream_m_valid_o = (count_r != ZERO_L);
    assign busy_o           = busy_r;
    assign irq_o            = irq_r;
    assign err_o            = err_r;

endmodule

// File: tb/tb_wb_stream_fetch.sv
// Directed bench for wb_stream_fetch with a 4-deep FIFO. A combinational
// zero-wait slave returns data = address, with optional retry/error beats.
// Expected bus beats and stream words are queued when a run is set up and
// popped by a monitor as the DUT produces them.
module tb_wb_stream_fetch;

    localparam int TB_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wbm_adr;
    logic [3:0]  wbm_sel;
    logic        wbm_we;
    logic        wbm_cyc;
    logic        wbm_stb;
    logic [2:0]  wbm_cti;
    logic [1:0]  wbm_bte;
    logic [31:0] wbm_dat;
    logic        wbm_ack;
    logic        wbm_err;
    logic        wbm_rty;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        enable;
    logic [31:0] start_adr;
    logic [31:0] buf_size;
    logic [31:0] burst_size;
    logic        busy;
    logic        irq;
    logic        err;

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
    } beat_t;

    beat_t       bq[$];
    logic [31:0] sq[$];
    beat_t       mon_b;
    logic [31:0] mon_w;
    int n_cmp   = 0;
    int n_bad   = 0;
    int irq_cnt = 0;
    int i0;
    int beat_cnt = 0;
    int err_at   = -1;
    int rty_at   = -1;
    int rty_hit  = -1;

    wb_stream_fetch #(
        .WB_DW(32), .WB_AW(32), .FIFO_AW(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wbm_adr_o(wbm_adr), .wbm_sel_o(wbm_sel), .wbm_we_o(wbm_we),
        .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb), .wbm_cti_o(wbm_cti),
        .wbm_bte_o(wbm_bte), .wbm_dat_i(wbm_dat), .wbm_ack_i(wbm_ack),
        .wbm_err_i(wbm_err), .wbm_rty_i(wbm_rty),
        .stream_m_data_o(s_data), .stream_m_valid_o(s_valid),
        .stream_m_ready_i(s_ready),
        .enable(enable), .start_adr(start_adr), .buf_size(buf_size),
        .burst_size(burst_size), .busy_o(busy), .irq_o(irq), .err_o(err)
    );

    always #5 clk = ~clk;

    // Slave: zero wait states, data mirrors the address.
    assign wbm_rty = wbm_cyc && wbm_stb && (beat_cnt == rty_at) && (rty_hit != beat_cnt);
    assign wbm_err = wbm_cyc && wbm_stb && (beat_cnt == err_at);
    assign wbm_ack = wbm_cyc && wbm_stb && !wbm_rty && !wbm_err;
    assign wbm_dat = wbm_adr;

    always @(posedge clk) begin
        if (wbm_cyc && wbm_stb && (wbm_ack || wbm_err)) beat_cnt <= beat_cnt + 1;
        if (wbm_rty) rty_hit <= beat_cnt;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [2:0] c);
        beat_t b;
        b.adr = a;
        b.cti = c;
        bq.push_back(b);
    endtask

    // Reference burst plan: clamp length to [1, TB_MAX], cut at buffer end.
    task automatic push_plan(input logic [31:0] start, input int bsz, input int burst);
        int eff;
        int idx;
        int n;
        eff = (burst == 0) ? 1 : ((burst > TB_MAX) ? TB_MAX : burst);
        idx = 0;
        while (idx < bsz) begin
            n = eff;
            if (bsz - idx < n) n = bsz - idx;
            for (int j = 0; j < n; j++) begin
                push_beat(start + 32'(4 * (idx + j)), (j == n - 1) ? 3'b111 : 3'b010);
                sq.push_back(start + 32'(4 * (idx + j)));
            end
            idx += n;
        end
    endtask

    task automatic cfg(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        start_adr  = a;
        buf_size   = b;
        burst_size = c;
    endtask

    task automatic wait_irq(input string tag, input bit drop);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (irq) break;
        end
        chk({tag, "_irq_seen"}, 32'(irq), 32'd1);
        if (drop) enable = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy && !s_valid && bq.size() == 0 && sq.size() == 0) break;
        end
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_bus_left"}, 32'(bq.size()), 32'd0);
        chk({tag, "_stream_left"}, 32'(sq.size()), 32'd0);
    endtask

    // Monitor: scoreboard check of every bus beat, stream word and irq cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wbm_cyc && wbm_stb && (wbm_ack || wbm_err)) begin
                chk("bus_sel", 32'(wbm_sel), 32'h0000000F);
                chk("bus_we_bte", {29'd0, wbm_we, wbm_bte}, 32'd0);
                if (bq.size() == 0) begin
                    chk("bus_unexpected_beat", 32'(bq.size()), 32'd1);
                end else begin
                    mon_b = bq.pop_front();
                    chk("bus_adr", wbm_adr, mon_b.adr);
                    chk("bus_cti", 32'(wbm_cti), 32'(mon_b.cti));
                end
            end
            if (s_valid && s_ready) begin
                if (sq.size() == 0) begin
                    chk("stream_unexpected_word", 32'(sq.size()), 32'd1);
                end else begin
                    mon_w = sq.pop_front();
                    chk("stream_data", s_data, mon_w);
                end
            end
            if (irq) irq_cnt++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; enable = 1'b0; s_ready = 1'b0;
        cfg(32'h0, 32'h0, 32'h0);
        #2 rst_n = 1'b0;
        step(2);
        chk("rst_cyc_stb", {30'd0, wbm_cyc, wbm_stb}, 32'd0);
        chk("rst_adr", wbm_adr, 32'd0);
        chk("rst_sel_cti", {25'd0, wbm_sel, wbm_cti}, 32'd0);
        chk("rst_flags", {28'd0, s_valid, busy, irq, err}, 32'd0);
        rst_n = 1'b1;
        step(2);

        // Zero-length buffer never leaves IDLE.
        enable = 1'b1;
        step(4);
        chk("zero_buf_idle", {30'd0, busy, wbm_cyc}, 32'd0);
        enable = 1'b0;
        step(1);

        // Basic fetch, with one retry wait state on the third beat.
        cfg(32'h1000, 32'd8, 32'd4);
        s_ready = 1'b1;
        push_plan(32'h1000, 8, 4);
        i0 = irq_cnt;
        rty_at = beat_cnt + 2;
        enable = 1'b1;
        @(negedge clk) chk("t1_busy_c0", 32'(busy), 32'd0);
        @(negedge clk) chk("t1_wait_c1", {30'd0, busy, wbm_cyc}, 32'd2);
        @(negedge clk) chk("t1_cyc_c2", 32'(wbm_cyc), 32'd1);
        wait_irq("t1", 1'b1);
        wait_idle("t1");
        chk("t1_irq_once", 32'(irq_cnt - i0), 32'd1);
        rty_at = -1;

        // Tail burst: 4 + 1 beats.
        cfg(32'h2000, 32'd5, 32'd4);
        push_plan(32'h2000, 5, 4);
        enable = 1'b1;
        wait_irq("t2", 1'b1);
        wait_idle("t2");

        // Burst length clamp (7 -> 4) and burst_size 0 treated as 1.
        cfg(32'h3000, 32'd6, 32'd7);
        push_plan(32'h3000, 6, 7);
        enable = 1'b1;
        wait_irq("t3a", 1'b1);
        wait_idle("t3a");
        cfg(32'h3800, 32'd2, 32'd0);
        push_plan(32'h3800, 2, 0);
        enable = 1'b1;
        wait_irq("t3b", 1'b1);
        wait_idle("t3b");

        // Backpressure: one burst fills the FIFO, then stalls.
        s_ready = 1'b0;
        cfg(32'h4000, 32'd8, 32'd4);
        push_plan(32'h4000, 8, 4);
        enable = 1'b1;
        step(20);
        chk("t4_no_cyc", 32'(wbm_cyc), 32'd0);
        chk("t4_bus_left", 32'(bq.size()), 32'd4);
        chk("t4_stream_left", 32'(sq.size()), 32'd8);
        chk("t4_valid_busy", {30'd0, s_valid, busy}, 32'd3);
        chk("t4_head_stable", s_data, 32'h4000);
        s_ready = 1'b1;
        wait_irq("t4", 1'b1);
        wait_idle("t4");

        // Bus error on beat 2 of 4.
        s_ready = 1'b0;
        cfg(32'h5000, 32'd8, 32'd4);
        push_beat(32'h5000, 3'b010);
        push_beat(32'h5004, 3'b010);
        sq.push_back(32'h5000);
        err_at = beat_cnt + 1;
        enable = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (err) break;
        end
        chk("t5_err_set", 32'(err), 32'd1);
        chk("t5_cyc_stb_drop", {30'd0, wbm_cyc, wbm_stb}, 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_valid", 32'(s_valid), 32'd1);
        err_at = -1;
        step(5);
        chk("t5_refused", {30'd0, busy, wbm_cyc}, 32'd0);
        chk("t5_one_word", 32'(sq.size()), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk) chk("t5_err_clear", 32'(err), 32'd0);
        s_ready = 1'b1;
        step(3);
        chk("t5_drained", {31'd0, s_valid}, 32'd0);
        chk("t5_stream_left", 32'(sq.size()), 32'd0);

        // Ring replay, then disable mid-burst of the second pass.
        cfg(32'h6000, 32'd4, 32'd2);
        push_plan(32'h6000, 4, 2);
        push_plan(32'h6000, 2, 2);
        i0 = irq_cnt;
        enable = 1'b1;
        wait_irq("t6", 1'b0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (wbm_cyc) break;
        end
        chk("t6_replay_adr", wbm_adr, 32'h6000);
        enable = 1'b0;
        wait_idle("t6");
        chk("t6_irq_once", 32'(irq_cnt - i0), 32'd1);

        // Asynchronous reset in the middle of a burst.
        s_ready = 1'b0;
        cfg(32'h7000, 32'd8, 32'd4);
        push_beat(32'h7000, 3'b010);
        enable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wbm_cyc) break;
        end
        chk("t7_cyc_up", 32'(wbm_cyc), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("t7_rst_cyc_stb", {30'd0, wbm_cyc, wbm_stb}, 32'd0);
        chk("t7_rst_valid_busy", {30'd0, s_valid, busy}, 32'd0);
        chk("t7_bus_left", 32'(bq.size()), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
        cfg(32'h7000, 32'd2, 32'd2);
        push_plan(32'h7000, 2, 2);
        s_ready = 1'b1;
        enable = 1'b1;
        wait_irq("t7", 1'b1);
        wait_idle("t7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_stream_fetch.md
# wb_stream_fetch

Wishbone-to-stream read DMA engine: a Wishbone master that fetches a memory buffer in incrementing bursts into an internal FIFO and presents it as a valid/ready stream. It is the memory-to-stream complement of the stream-to-memory writer. Configuration (enable, start address, buffer size, burst size) comes from a register block through plain ports.

## Interface
- WB_DW, 32, Wishbone and stream data width; must be a multiple of 8
- WB_AW, 32, Wishbone address width (byte addresses)
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW words
- MAX_BURST_LEN, 2**FIFO_AW, maximum beats per burst; must be ≤ FIFO depth

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- wbm_adr_o  out  WB_AW  byte address of the current beat
- wbm_sel_o  out  WB_DW/8  all ones while cyc is high, else 0
- wbm_we_o  out  1  constant 0
- wbm_cyc_o, wbm_stb_o  out  1  bus cycle / strobe
- wbm_cti_o  out  3  010 incrementing, 111 last beat
- wbm_bte_o  out  2  constant 00 (linear)
- wbm_dat_i  in  WB_DW  read data
- wbm_ack_i, wbm_err_i, wbm_rty_i  in  1  slave responses
- stream_m_data_o  out  WB_DW  stream data
- stream_m_valid_o  out  1  stream data valid
- stream_m_ready_i  in  1  stream sink ready
- enable  in  1  level; high = run
- start_adr  in  WB_AW  buffer base byte address, word-aligned
- buf_size  in  WB_AW  buffer length in words
- burst_size  in  WB_AW  beats per burst
- busy_o  out  1  high when not IDLE
- irq_o  out  1  one-cycle pulse when the last buffer word is acked
- err_o  out  1  sticky bus-error flag

## Operation
- All outputs reset to 0, FSM to IDLE, word index and FIFO pointers to 0.
- Effective burst length = clamp(burst_size, 1, MAX_BURST_LEN); burst_size 0 is treated as 1. Each burst issues min(effective length, buf_size − idx) beats.
- FSM states:
  - IDLE: idx = 0. Moves to WAIT when enable=1, buf_size≠0, and err_o=0.
  - WAIT: moves to BURST when FIFO free space (depth − count) ≥ the burst's beat count; moves to IDLE if enable=0.
  - BURST: cyc=stb=1, adr = start_adr + idx·(WB_DW/8), cti=010 except on the last beat, where cti=111 (a single-beat burst uses 111 only).
- On each ack in BURST:
  - write wbm_dat_i to the FIFO;
  - idx += 1, and the address advances;
  - after the last beat, cyc/stb drop.
- End of buffer: when idx reaches buf_size on an ack, irq_o pulses, idx wraps to 0, and the next state is WAIT if enable=1, else IDLE. This gives a ring-buffer replay while enable is held.
- enable deasserted mid-burst: the current burst completes (no Wishbone abort), then the FSM goes to IDLE. FIFO contents still drain to the stream.
- rty during a beat: treated as a wait state; the same beat is held.
- err during a beat:
  - the beat is not written to the FIFO;
  - cyc/stb drop the next cycle;
  - err_o is set and the FSM goes to IDLE.
  - err_o clears only when enable=0 (next cycle). Simultaneous ack and err: err wins.
- Config inputs are sampled only at WAIT→BURST; changes mid-burst take effect at the next burst.
- FIFO: first-word-fall-through, with simultaneous write and read in the same cycle allowed. stream_m_valid_o = not empty. stream_m_data_o is stable while valid=1 and ready=0. It cannot overflow because of the WAIT space check.

## Timing
- All Wishbone master outputs are registered.
- enable rising edge in IDLE with an empty FIFO: WAIT on cycle 1, cyc/stb high on cycle 2.
- Ack at cycle t:
  - the FIFO write lands at the t edge;
  - stream_m_valid_o is high at t+1 if the FIFO was empty;
  - adr/cti update at t+1.
- Last ack at cycle t: cyc/stb=0 at t+1 (WAIT). The next burst asserts at t+2 at the earliest, so there is at least one idle cycle between bursts.
- irq_o is high exactly during cycle t+1 after the final-word ack.
- busy_o = (state ≠ IDLE).
- Reset asserted mid-burst: cyc/stb and all outputs go to 0 asynchronously, and the FIFO is emptied.
- Stream throughput: 1 word/cycle when ready=1 and the FIFO is non-empty.

## Test plan
- Basic fetch:
  - Stimulus: start_adr=0x1000, buf_size=8, burst_size=4, ready=1, zero-wait-state slave returning data=address.
  - Required: two bursts with adr 0x1000..0x100C then 0x1010..0x101C; cti 010,010,010,111 per burst; stream emits 0x1000..0x101C in order; irq_o pulses once.
- Tail burst: buf_size=5, burst_size=4.
  - Required: bursts of 4 and 1 beats; the single beat has cti=111; 5 stream words.
- Backpressure:
  - Stimulus: FIFO_AW=2, burst_size=4, ready=0.
  - Required: exactly one burst fills the FIFO, no second cyc; releasing ready drains 4 words and a new burst starts.
- Error:
  - Stimulus: err_i on beat 2 of 4.
  - Required: 1 word in FIFO, cyc=0 next cycle, err_o=1, busy_o=0; re-enable refused until enable=0 clears err_o.
- Wrap/disable:
  - Stimulus: buf_size=4, enable held high.
  - Required: second pass restarts at start_adr after irq_o. Dropping enable mid-burst completes that burst, then IDLE.
- Reset: rst_n low during BURST.
  - Required: cyc/stb/valid immediately 0; a fresh run after release starts at start_adr.
